// File: rtl/riscv_multicycle_control.sv
// rtl/riscv_multicycle_control.sv - main control FSM for the multi-cycle RV32 datapath
module riscv_multicycle_control #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int STATE_W        = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instruction,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               pc_source,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         ALUOp,
  output logic               illegal_instr,
  output logic               mem_timeout,
  output logic [31:0]        instr_retired,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = STATE_W'(0),
    S_DECODE  = STATE_W'(1),
    S_MEMADR  = STATE_W'(2),
    S_MEMRD   = STATE_W'(3),
    S_MEMWB   = STATE_W'(4),
    S_MEMWR   = STATE_W'(5),
    S_EXEC    = STATE_W'(6),
    S_ADDI_EX = STATE_W'(7),
    S_ALUWB   = STATE_W'(8),
    S_BRANCH  = STATE_W'(9)
  } state_t;

  localparam logic [6:0]  OP_R    = 7'b0110011;
  localparam logic [6:0]  OP_ADDI = 7'b0010011;
  localparam logic [6:0]  OP_LW   = 7'b0000011;
  localparam logic [6:0]  OP_SW   = 7'b0100011;
  localparam logic [6:0]  OP_BEQ  = 7'b1100011;
  localparam logic [15:0] TO_LIM  = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_tcnt;
  logic [31:0] r_retired;
  logic        r_illegal;
  logic        r_timeout;
  logic        w_illegal;
  logic        w_retire;
  logic        w_wait;
  logic        w_timeout;
  logic [6:0]  w_opcode;
  logic        w_unused;

  assign w_opcode  = instruction[6:0];
  assign w_unused  = ^{instruction[31:7], zero};
  assign w_wait    = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // Ready on the limit cycle wins over the abort.
  assign w_timeout = w_wait && !mem_ready && (r_tcnt == TO_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_tcnt    <= 16'd0;
      r_retired <= 32'd0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_illegal;
      r_timeout <= w_timeout;
      r_retired <= r_retired + 32'(w_retire);
      if ((w_next != r_state) || w_timeout) begin
        r_tcnt <= 16'd0;
      end else if (w_wait) begin
        r_tcnt <= r_tcnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_next        = S_FETCH;
    w_illegal     = 1'b0;
    w_retire      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    ALUOp         = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        w_next    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        case (w_opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXEC;
          OP_ADDI:      w_next = S_ADDI_EX;
          OP_BEQ:       w_next = S_BRANCH;
          default:      w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        w_next    = (w_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        w_next   = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_retire   = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        w_retire  = mem_ready;
        w_next    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 2'b01;
        ALUOp     = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ADDI_EX: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        w_retire  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b01;
        ALUOp         = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        w_retire      = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    if (w_timeout) begin
      w_next = S_FETCH;
    end
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      ALUOp         = 2'b00;
    end
  end

  assign illegal_instr = r_illegal & ~reset;
  assign mem_timeout   = r_timeout & ~reset;
  assign instr_retired = r_retired;
  assign state         = r_state;

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// tb/tb_riscv_multicycle_control.sv - scoreboard bench for riscv_multicycle_control
module tb_riscv_multicycle_control;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset, mem_ready, zero;
  logic [31:0] instruction;
  logic        pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write;
  logic        ir_write, mem_to_reg, reg_write, illegal_instr, mem_timeout;
  logic [1:0]  alu_src_a, alu_src_b, ALUOp;
  logic [31:0] instr_retired;
  logic [3:0]  state;

  riscv_multicycle_control #(.TIMEOUT_CYCLES(T), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp(ALUOp),
    .illegal_instr(illegal_instr), .mem_timeout(mem_timeout), .instr_retired(instr_retired),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [16:0] ctl;
    logic [3:0]  st;
    logic [31:0] ret;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_ret;
  bit          p_ill, p_to;

  localparam logic [6:0] OP_R = 7'b0110011, OP_ADDI = 7'b0010011, OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011, OP_BEQ = 7'b1100011;

  // Control word order: pcw pcwc pcs iord mr mw irw m2r rw a[2] b[2] op[2]
  function automatic logic [14:0] mk(input bit pcw, pcwc, pcs, io, mr, mw, irw, m2r, rw,
                                     input logic [1:0] a, b, op);
    return {pcw, pcwc, pcs, io, mr, mw, irw, m2r, rw, a, b, op};
  endfunction

  logic [14:0] F_WAIT, F_RDY, DEC, MADR, MRD, MWB, MWR, EXE, ADX, AWB, BR;

  wire [16:0] act_ctl = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
                         mem_to_reg, reg_write, alu_src_a, alu_src_b, ALUOp, illegal_instr, mem_timeout};

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({act_ctl, state, instr_retired} !== {e.ctl, e.st, e.ret}) begin
        errors++;
        $display("FAIL %s @%0t: got ctl=%h state=%0d retired=%0d, expected ctl=%h state=%0d retired=%0d",
                 e.name, $time, act_ctl, state, instr_retired, e.ctl, e.st, e.ret);
      end
    end
  end

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input string nm, input bit rst, input bit rdy, input bit z,
                      input logic [14:0] ctl, input int st, input bit ret, input bit ill, input bit to);
    exp_t e;
    reset     = rst;
    mem_ready = rdy;
    zero      = z;
    e.name = nm;
    e.ctl  = rst ? 17'd0 : {ctl, p_ill, p_to};
    e.st   = st[3:0];
    e.ret  = m_ret;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (rst) begin
      m_ret = 0; p_ill = 0; p_to = 0;
    end else begin
      if (ret) m_ret++;
      p_ill = ill;
      p_to  = to;
    end
  endtask

  // n cycles without ready, then one ready cycle; aborts on the T-th idle cycle.
  task automatic wait_phase(input string nm, input int n, input logic [14:0] c_wait, c_rdy,
                            input int st, input bit z, input bit ret, output bit aborted);
    aborted = 0;
    for (int i = 0; i < n; i++) begin
      step(nm, 0, 0, z, c_wait, st, 0, 0, i == T - 1);
      if (i == T - 1) begin
        aborted = 1;
        return;
      end
    end
    step(nm, 0, 1, z, c_rdy, st, ret, 0, 0);
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input bit z);
    bit ab;
    int rem;
    rem = fw;
    instruction = ins;
    do begin
      wait_phase("fetch", rem, F_WAIT, F_RDY, 0, z, 0, ab);
      rem -= T;
    end while (ab);
    case (ins[6:0])
      OP_LW: begin
        step("decode", 0, rb(), z, DEC, 1, 0, 0, 0);
        step("memadr", 0, rb(), z, MADR, 2, 0, 0, 0);
        wait_phase("memrd", mw, MRD, MRD, 3, z, 0, ab);
        if (!ab) step("memwb", 0, rb(), z, MWB, 4, 1, 0, 0);
      end
      OP_SW: begin
        step("decode", 0, rb(), z, DEC, 1, 0, 0, 0);
        step("memadr", 0, rb(), z, MADR, 2, 0, 0, 0);
        wait_phase("memwr", mw, MWR, MWR, 5, z, 1, ab);
      end
      OP_R: begin
        step("decode", 0, rb(), z, DEC, 1, 0, 0, 0);
        step("exec", 0, rb(), z, EXE, 6, 0, 0, 0);
        step("aluwb", 0, rb(), z, AWB, 8, 1, 0, 0);
      end
      OP_ADDI: begin
        step("decode", 0, rb(), z, DEC, 1, 0, 0, 0);
        step("addi_ex", 0, rb(), z, ADX, 7, 0, 0, 0);
        step("aluwb", 0, rb(), z, AWB, 8, 1, 0, 0);
      end
      OP_BEQ: begin
        step("decode", 0, rb(), z, DEC, 1, 0, 0, 0);
        step("branch", 0, rb(), z, BR, 9, 1, 0, 0);
      end
      default: step("decode_illegal", 0, rb(), z, DEC, 1, 0, 1, 0);
    endcase
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  op;
    int          k;
    F_WAIT = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00);
    F_RDY  = mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00);
    DEC    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00);
    MADR   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00);
    MRD    = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    MWB    = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00);
    MWR    = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    EXE    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10);
    ADX    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00);
    AWB    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);
    BR     = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01);
    m_ret = 0; p_ill = 0; p_to = 0;
    reset = 1; mem_ready = 1; zero = 0; instruction = 32'h0;
    @(posedge clk);
    #1;
    step("reset", 1, 1, 0, 15'd0, 0, 0, 0, 0);
    step("reset", 1, 0, 0, 15'd0, 0, 0, 0, 0);

    run_instr(32'h002081B3, 0, 0, 0);
    run_instr(32'h0000A103, 0, 3, 0);
    run_instr(32'h00208463, 0, 0, 1);
    run_instr(32'h00208463, 0, 0, 0);
    run_instr(32'h0000007F, 0, 0, 0);
    run_instr(32'h0020A023, 0, 5, 0);
    run_instr(32'h00108093, 4, 0, 0);
    run_instr(32'h0020A023, 2, 3, 1);

    instruction = 32'h0000A103;
    step("fetch", 0, 1, 0, F_RDY, 0, 0, 0, 0);
    step("decode", 0, 0, 0, DEC, 1, 0, 0, 0);
    step("memadr", 0, 1, 0, MADR, 2, 0, 0, 0);
    step("reset_mid", 1, 1, 0, 15'd0, 3, 0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      r = $urandom;
      k = $urandom_range(0, 5);
      case (k)
        0: op = OP_R;
        1: op = OP_ADDI;
        2: op = OP_LW;
        3: op = OP_SW;
        4: op = OP_BEQ;
        default: begin
          do op = 7'($urandom);
          while (op == OP_R || op == OP_ADDI || op == OP_LW || op == OP_SW || op == OP_BEQ);
        end
      endcase
      run_instr({r[31:7], op}, $urandom_range(0, 5), $urandom_range(0, 5), rb());
    end
    step("final", 0, 0, 0, F_WAIT, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscv_multicycle_control.md
Name: riscv_multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32 datapath. Decodes `instruction[6:0]` from the instruction register and sequences the fetch, decode, execute, memory and writeback steps.
- Drives the 2-bit `ALUOp` consumed by the ALU control decoder (00 = ADD, 01 = SUB compare, 10 = R-type funct decode), plus every datapath mux and enable.
- Handshakes with unified instruction/data memory via `mem_ready`.
- Supported instructions: R-type (0110011), ADDI (0010011), LW (0000011), SW (0100011), BEQ (1100011).

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in a memory wait state before abort; legal range 1..65535.
- STATE_W, 4: width of the state register and of the debug `state` output.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- instruction  input  32  current instruction register contents
- mem_ready  input  1  memory has completed the current read/write this cycle
- zero  input  1  ALU zero flag
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by `zero`
- pc_source  output  1  0 = ALU result, 1 = ALUOut register
- iord  output  1  0 = memory address from PC, 1 = from ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  register writeback source: 1 = MDR, 0 = ALUOut
- reg_write  output  1  register file write enable
- alu_src_a  output  2  ALU operand A: 00 = PC, 01 = rs1 register A, 10 = oldPC
- alu_src_b  output  2  ALU operand B: 00 = register B, 01 = constant 4, 10 = immediate
- ALUOp  output  2  operation class for the ALU control decoder
- illegal_instr  output  1  one-cycle pulse on an unsupported opcode
- mem_timeout  output  1  one-cycle pulse on a memory wait abort
- instr_retired  output  32  count of completed instructions
- state  output  STATE_W  current FSM state, for debug

Behaviour:
- Reset is synchronous. With `reset` high at a clock edge:
  - state returns to FETCH;
  - `instr_retired` and the timeout counter clear to 0;
  - pulse flags clear.
- While `reset` is high, all control outputs are forced to 0, overriding the state decode.
- Reset mid-operation aborts the current instruction with no further write enables.
- Control outputs are Moore decodes of state, except that `ir_write` and `pc_write` in FETCH are gated by `mem_ready`. Any output not listed for a state is 0.
- FETCH (0):
  - outputs: `mem_read`=1, `iord`=0, `alu_src_a`=00, `alu_src_b`=01, `ALUOp`=00, `pc_source`=0;
  - `ir_write` and `pc_write` equal `mem_ready`;
  - go to DECODE on `mem_ready`, otherwise stay.
- DECODE (1):
  - outputs: `alu_src_a`=10, `alu_src_b`=10, `ALUOp`=00 (branch target into ALUOut);
  - next state by opcode: LW or SW -> MEMADR, R-type -> EXEC, ADDI -> ADDI_EX, BEQ -> BRANCH;
  - any other opcode: `illegal_instr` pulses for 1 cycle, go to FETCH, counter not incremented.
- MEMADR (2):
  - outputs: `alu_src_a`=01, `alu_src_b`=10, `ALUOp`=00;
  - opcode LW -> MEMRD, SW -> MEMWR.
- MEMRD (3): `mem_read`=1, `iord`=1; on `mem_ready` go to MEMWB.
- MEMWB (4): `reg_write`=1, `mem_to_reg`=1; go to FETCH.
- MEMWR (5): `mem_write`=1, `iord`=1; on `mem_ready` go to FETCH.
- EXEC (6): `alu_src_a`=01, `alu_src_b`=00, `ALUOp`=10; go to ALUWB.
- ADDI_EX (7): `alu_src_a`=01, `alu_src_b`=10, `ALUOp`=00; go to ALUWB.
- ALUWB (8): `reg_write`=1, `mem_to_reg`=0; go to FETCH.
- BRANCH (9):
  - outputs: `alu_src_a`=01, `alu_src_b`=00, `ALUOp`=01, `pc_write_cond`=1, `pc_source`=1;
  - go to FETCH.
  - PC loads only when `zero`=1; the instruction is counted as retired either way.
- Latencies with `mem_ready` asserted immediately:
  - R-type, ADDI: 4 cycles;
  - BEQ: 3 cycles;
  - SW: 4 cycles;
  - LW: 5 cycles;
  - each memory wait adds its extra cycles.
- `instr_retired` increments by 1 on the transition out of MEMWB, MEMWR (on `mem_ready`), ALUWB and BRANCH. It wraps from 0xFFFFFFFF to 0.
- Timeout, in wait states FETCH, MEMRD and MEMWR:
  - the counter clears on entry to a wait state and increments each cycle without `mem_ready`;
  - if `mem_ready` is still 0 when the counter reaches TIMEOUT_CYCLES-1, `mem_timeout` pulses for 1 cycle and the FSM goes to FETCH;
  - the aborted instruction is not retired and no write enable is issued.
- `mem_ready` in the same cycle as the timeout limit: ready wins, no timeout.
- `mem_ready` seen outside a wait state is ignored.
- Unused encodings 10..15 go to FETCH on the next cycle with all outputs 0.

Test Plan:
- Reset held 2 cycles, then release -> all outputs 0 during reset; `state`=0, `mem_read`=1, `instr_retired`=0 after release.
- R-type ADD (0x002081B3) with `mem_ready` tied to 1 -> states 0,1,6,8; `ALUOp`=10 in EXEC; `reg_write` for 1 cycle; `instr_retired`=1 after 4 cycles.
- LW (0x0000A103) with `mem_ready` low for 3 cycles in MEMRD -> MEMRD held 4 cycles; then MEMWB with `mem_to_reg`=1, `reg_write`=1; 8 cycles total.
- BEQ (0x00208463) run twice, with `zero`=1 then `zero`=0 -> `pc_write_cond`=1, `ALUOp`=01 in BRANCH both times; counter increments by 2 total.
- Opcode 0x7F in DECODE -> `illegal_instr` pulses for 1 cycle, state returns to 0, `instr_retired` unchanged.
- TIMEOUT_CYCLES=4 with `mem_ready`=0 in MEMWR -> `mem_timeout` pulses after 4 wait cycles; `mem_write` then drops; state=0; counter unchanged.
